// File: rtl/mem_xfer_unit.sv
// Memory transfer unit: sequences FETCH/LOAD/STORE/PUSH/POP accesses with PC/SP upkeep,
// a bounded wait for MEM_READY and a one-cycle DONE/ERR response.
module mem_xfer_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter logic [ADDR_WIDTH-1:0] INST_START_ADDR = ADDR_WIDTH'('h0001000),
  parameter logic [ADDR_WIDTH-1:0] INIT_STACK_POINTER = ADDR_WIDTH'('h3FFFFFF),
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic [2:0]            OP,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  PC_LOAD,
  input  logic [ADDR_WIDTH-1:0] PC_NEXT,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  input  logic                  MEM_READY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] SP,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] pc_d, sp_d, maddr_d;
  logic [DATA_WIDTH-1:0] inst_d, rdata_d, mwdata_d;
  logic                  mread_d, mwrite_d, busy_d, done_d, err_d;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  req_rd, req_wr, acc_rd, acc_wr;

  // Request decode (IDLE side) and held-op decode (ACCESS side)
  assign fetch_addr = PC_LOAD ? PC_NEXT : PC;
  assign req_rd     = (OP == OP_FETCH) || (OP == OP_LOAD) || (OP == OP_POP);
  assign req_wr     = (OP == OP_STORE) || (OP == OP_PUSH);
  assign acc_rd     = (op_q == OP_FETCH) || (op_q == OP_LOAD) || (op_q == OP_POP);
  assign acc_wr     = (op_q == OP_STORE) || (op_q == OP_PUSH);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FETCH;
      wait_q      <= '0;
      PC          <= INST_START_ADDR;
      SP          <= INIT_STACK_POINTER;
      INSTRUCTION <= '0;
      RDATA       <= '0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      PC          <= pc_d;
      SP          <= sp_d;
      INSTRUCTION <= inst_d;
      RDATA       <= rdata_d;
      MEM_ADDR    <= maddr_d;
      MEM_WDATA   <= mwdata_d;
      MEM_READ    <= mread_d;
      MEM_WRITE   <= mwrite_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
      ERR         <= err_d;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    pc_d     = PC;
    sp_d     = SP;
    inst_d   = INSTRUCTION;
    rdata_d  = RDATA;
    maddr_d  = MEM_ADDR;
    mwdata_d = MEM_WDATA;
    mread_d  = 1'b0;
    mwrite_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (PC_LOAD) pc_d = PC_NEXT;
        if (REQ) begin
          op_d   = OP;
          busy_d = 1'b1;
          if (req_rd || req_wr) begin
            case (OP)
              OP_FETCH: maddr_d = fetch_addr;
              OP_PUSH:  maddr_d = SP;
              OP_POP:   maddr_d = SP + ADDR_WIDTH'(1);
              default:  maddr_d = ADDR_IN;
            endcase
            mwdata_d = WDATA;
            wait_d   = '0;
            mread_d  = req_rd;
            mwrite_d = req_wr;
            state_d  = S_ACCESS;
          end else begin
            // Illegal opcode: no memory strobe, straight to an error response
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_ACCESS: begin
        busy_d = 1'b1;
        if (MEM_READY) begin
          case (op_q)
            OP_FETCH: begin
              inst_d = MEM_RDATA;
              pc_d   = PC + ADDR_WIDTH'(1);
            end
            OP_LOAD: rdata_d = MEM_RDATA;
            OP_PUSH: sp_d = SP - ADDR_WIDTH'(1);
            OP_POP: begin
              rdata_d = MEM_RDATA;
              sp_d    = SP + ADDR_WIDTH'(1);
            end
            default: ;
          endcase
          done_d  = 1'b1;
          state_d = S_RESP;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wait_d   = wait_q + WAIT_W'(1);
          mread_d  = acc_rd;
          mwrite_d = acc_wr;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule
